vnu_ppl: RTL and testbench

- Pipelined variable node unit for the min-sum LDPC decoder; the counterpart of the check node unit.
- Consumes D check-to-variable messages r plus the channel LLR and produces D variable-to-check messages q and a hard decision.
- q lanes feed the CNU q bus directly: same lane order, same data_w two's complement format.
- Two-stage pipeline, one new message set accepted per clock, no backpressure.

---
 rtl/vnu_ppl_if.sv | 25 ++
 rtl/vnu_ppl.sv | 102 ++++++++++
 tb/tb_vnu_ppl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/vnu_ppl_if.sv
// Message bus of the variable node unit: channel LLR load, r lanes in,
// q lanes plus hard decision out.
interface vnu_ppl_if #(
  parameter int data_w = 8,
  parameter int D      = 3
);
  logic                  llr_load;
  logic [data_w-1:0]     llr_in;
  logic                  in_valid;
  logic [data_w*D-1:0]   r;
  logic                  out_valid;
  logic [data_w*D-1:0]   q;
  logic                  hd;
  logic                  hd_changed;

  modport master (
    output llr_load, llr_in, in_valid, r,
    input  out_valid, q, hd, hd_changed
  );

  modport slave (
    input  llr_load, llr_in, in_valid, r,
    output out_valid, q, hd, hd_changed
  );
endinterface

// File: rtl/vnu_ppl.sv
// Two-stage min-sum variable node: stage 1 sums LLR and r lanes,
// stage 2 forms saturated extrinsic q lanes and the hard decision.
module vnu_ppl #(
  parameter int data_w = 8,
  parameter int D      = 3,
  parameter int sum_w  = data_w + 2
) (
  input  logic   clk,
  input  logic   rst,
  vnu_ppl_if.slave bus
);
  localparam logic signed [sum_w-1:0] q_max = sum_w'(2**(data_w-1) - 1);
  localparam logic signed [sum_w-1:0] q_min = -q_max;

  logic signed [data_w-1:0] llr_reg;
  logic                     first_flag;

  logic signed [data_w-1:0] eff_llr;
  logic                     eff_first;
  logic signed [data_w-1:0] eff_r [D];
  logic signed [sum_w-1:0]  total_c;

  logic                     s1_valid;
  logic                     s1_first;
  logic signed [sum_w-1:0]  s1_total;
  logic signed [data_w-1:0] s1_r [D];

  logic signed [sum_w-1:0]  diff [D];
  logic [data_w*D-1:0]      q_next;
  logic                     hd_next;
  logic                     hdc_next;

  logic                     out_valid_reg;
  logic [data_w*D-1:0]      q_reg;
  logic                     hd_reg;
  logic                     hdc_reg;

  // A same-cycle llr_load bypasses the LLR register and forces first mode.
  always_comb begin
    eff_llr   = bus.llr_load ? bus.llr_in : llr_reg;
    eff_first = bus.llr_load | first_flag;
    total_c   = sum_w'(eff_llr);
    for (int unsigned i = 0; i < D; i++) begin
      eff_r[i] = eff_first ? '0 : bus.r[i*data_w +: data_w];
      total_c  = total_c + sum_w'(eff_r[i]);
    end
  end

  // hd_reg only updates on valid outputs, so it doubles as hd_prev.
  always_comb begin
    q_next   = '0;
    for (int unsigned i = 0; i < D; i++) begin
      diff[i] = s1_total - sum_w'(s1_r[i]);
      if (diff[i] > q_max)
        q_next[i*data_w +: data_w] = data_w'(q_max);
      else if (diff[i] < q_min)
        q_next[i*data_w +: data_w] = data_w'(q_min);
      else
        q_next[i*data_w +: data_w] = data_w'(diff[i]);
    end
    hd_next  = s1_total[sum_w-1];
    hdc_next = s1_first | (hd_next != hd_reg);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      llr_reg       <= '0;
      first_flag    <= 1'b1;
      s1_valid      <= 1'b0;
      s1_first      <= 1'b0;
      s1_total      <= '0;
      for (int unsigned i = 0; i < D; i++) s1_r[i] <= '0;
      out_valid_reg <= 1'b0;
      q_reg         <= '0;
      hd_reg        <= 1'b0;
      hdc_reg       <= 1'b0;
    end else begin
      if (bus.llr_load) llr_reg <= bus.llr_in;
      if (bus.in_valid)      first_flag <= 1'b0;
      else if (bus.llr_load) first_flag <= 1'b1;

      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_total <= total_c;
        s1_first <= eff_first;
        for (int unsigned i = 0; i < D; i++) s1_r[i] <= eff_r[i];
      end

      out_valid_reg <= s1_valid;
      if (s1_valid) begin
        q_reg   <= q_next;
        hd_reg  <= hd_next;
        hdc_reg <= hdc_next;
      end
    end
  end

  assign bus.out_valid  = out_valid_reg;
  assign bus.q          = q_reg;
  assign bus.hd         = hd_reg;
  assign bus.hd_changed = hdc_reg;
endmodule

// File: tb/tb_vnu_ppl.sv
// Directed vector bench for vnu_ppl: table of per-cycle inputs with the
// q/hd/hd_changed each input must produce two edges later.
module tb_vnu_ppl;
  localparam int data_w = 8;
  localparam int D      = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vnu_ppl_if #(.data_w(data_w), .D(D)) bus ();

  vnu_ppl #(.data_w(data_w), .D(D), .sum_w(data_w + 2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit ld;
    int llr;
    bit v;
    int r [3];
    int q [3];
    bit hd;
    bit hdc;
  } vec_t;

  vec_t vecs [$];
  int   n_vec = 0;
  int   n_err = 0;
  int   last_q [3] = '{0, 0, 0};
  bit   last_hd = 1'b0;
  bit   last_hdc = 1'b0;

  task automatic add(input bit ld, input int llr, input bit v,
                     input int r0, input int r1, input int r2,
                     input int q0, input int q1, input int q2,
                     input bit hd, input bit hdc);
    vec_t t;
    t.ld = ld; t.llr = llr; t.v = v;
    t.r = '{r0, r1, r2};
    t.q = '{q0, q1, q2};
    t.hd = hd; t.hdc = hdc;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lane(input int l);
    logic signed [data_w-1:0] x;
    x = bus.q[l*data_w +: data_w];
    return int'(x);
  endfunction

  task automatic drive(input vec_t t);
    bus.llr_load = t.ld;
    bus.llr_in   = data_w'(t.llr);
    bus.in_valid = t.v;
    bus.r        = {data_w'(t.r[2]), data_w'(t.r[1]), data_w'(t.r[0])};
  endtask

  task automatic drive_idle();
    bus.llr_load = 1'b0;
    bus.llr_in   = '0;
    bus.in_valid = 1'b0;
    bus.r        = '0;
  endtask

  // Invalid slots must keep out_valid low and hold the previous results.
  task automatic check_out(input vec_t t, input int idx);
    string s;
    s = $sformatf("v%0d", idx);
    chk({s, ".out_valid"}, int'(bus.out_valid), int'(t.v));
    if (t.v) begin
      for (int l = 0; l < 3; l++) chk($sformatf("%s.q%0d", s, l), lane(l), t.q[l]);
      chk({s, ".hd"}, int'(bus.hd), int'(t.hd));
      chk({s, ".hd_changed"}, int'(bus.hd_changed), int'(t.hdc));
      last_q = t.q; last_hd = t.hd; last_hdc = t.hdc;
    end else begin
      for (int l = 0; l < 3; l++) chk($sformatf("%s.hold_q%0d", s, l), lane(l), last_q[l]);
      chk({s, ".hold_hd"}, int'(bus.hd), int'(last_hd));
      chk({s, ".hold_hdc"}, int'(bus.hd_changed), int'(last_hdc));
    end
  endtask

  initial begin
    //    ld llr   v  r0    r1    r2     q0    q1    q2   hd hdc
    add(1,  10,  0,   0,    0,    0,     0,    0,    0,  0, 0);
    add(0,   0,  1,   0,    0,    0,    10,   10,   10,  0, 1);
    add(0,   0,  1,   5,   -3,    7,    14,   22,   12,  0, 0);
    add(1, -20,  1,  50,   50,   50,   -20,  -20,  -20,  1, 1);
    add(0,   0,  0,   0,    0,    0,     0,    0,    0,  0, 0);
    add(1, 127,  0,   0,    0,    0,     0,    0,    0,  0, 0);
    add(0,   0,  1,   1,    2,    3,   127,  127,  127,  0, 1);
    add(0,   0,  1, 127,  127,  127,   127,  127,  127,  0, 0);
    add(1,-100,  1,   9,    9,    9,  -100, -100, -100,  1, 1);
    add(0,   0,  1,-100, -100, -100,  -127, -127, -127,  1, 0);
    add(1,   3,  1,   0,    0,    0,     3,    3,    3,  0, 1);
    add(0,   0,  1,  -1,   -1,   -1,     1,    1,    1,  0, 0);
    add(0,   0,  1, -10,    2,    1,     6,   -6,   -5,  1, 1);
    add(0,   0,  1,   4,    4,    4,    11,   11,   11,  0, 1);
    add(0,   0,  1,  -2,   -3,   -4,    -4,   -3,   -2,  1, 1);
    add(0,   0,  1,  -1,    0,    0,     3,    2,    2,  0, 1);
    add(0,   0,  1,-128, -128, -128,  -127, -127, -127,  1, 1);
    add(0,   0,  0,   0,    0,    0,     0,    0,    0,  0, 0);
    add(0,   0,  0,   0,    0,    0,     0,    0,    0,  0, 0);
    add(0,   0,  1,  10,    0,    0,     3,   13,   13,  0, 1);
    add(1,  50,  0,   0,    0,    0,     0,    0,    0,  0, 0);
    add(0,   0,  0,   0,    0,    0,     0,    0,    0,  0, 0);

    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", int'(bus.out_valid), 0);
    chk("reset.q", int'(bus.q), 0);
    chk("reset.hd", int'(bus.hd), 0);
    chk("reset.hd_changed", int'(bus.hd_changed), 0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size() + 2; i++) begin
      @(posedge clk);
      #1;
      if (i >= 2) check_out(vecs[i-2], i - 2);
      if (i < vecs.size()) drive(vecs[i]);
      else drive_idle();
    end

    // Reset one cycle after acceptance drops the in-flight set.
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.r        = {8'sd1, 8'sd1, 8'sd1};
    @(posedge clk); #1;
    drive_idle();
    rst = 1'b0;
    #1;
    chk("rst_mid.out_valid", int'(bus.out_valid), 0);
    chk("rst_mid.q", int'(bus.q), 0);
    chk("rst_mid.hd", int'(bus.hd), 0);
    chk("rst_mid.hd_changed", int'(bus.hd_changed), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_drop%0d.out_valid", k), int'(bus.out_valid), 0);
    end
    bus.in_valid = 1'b1;
    bus.r        = {8'sd5, 8'sd5, 8'sd5};
    @(posedge clk); #1;
    drive_idle();
    @(posedge clk); #1;
    chk("post_rst.out_valid", int'(bus.out_valid), 1);
    for (int l = 0; l < 3; l++) chk($sformatf("post_rst.q%0d", l), lane(l), 0);
    chk("post_rst.hd", int'(bus.hd), 0);
    chk("post_rst.hd_changed", int'(bus.hd_changed), 1);
    @(posedge clk); #1;
    chk("post_rst.single", int'(bus.out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
